// File: rtl/imem_fetch_ctrl_if.sv
// Bundle of the loader port, the instruction-memory port, the pipeline
// control inputs and the IF/ID outputs of the fetch controller.
// The controller connects through 'master'; the environment through 'slave'.
interface imem_fetch_ctrl_if;
    // byte-serial program loader
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_last;
    logic        load_ready;
    // instruction memory
    logic [63:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [31:0] instruction;
    // pipeline control
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    // IF/ID register and status
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        running;
    logic        fault;

    modport master (
        input  load_valid, load_byte, load_last, instruction,
               stall, redirect_valid, redirect_pc,
        output load_ready, mem_addr, mem_we, mem_wdata,
               if_pc, if_instr, if_valid, running, fault
    );

    modport slave (
        output load_valid, load_byte, load_last, instruction,
               stall, redirect_valid, redirect_pc,
        input  load_ready, mem_addr, mem_we, mem_wdata,
               if_pc, if_instr, if_valid, running, fault
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory sequencer: byte-serial program load after reset, then
// PC-driven fetch into the IF/ID register under stall/redirect control.
// Any misaligned or out-of-range fetch address parks the block in a sticky
// FAULT state until the next reset.
module imem_fetch_ctrl #(
    parameter int          MEM_BYTES = 128,
    parameter logic [63:0] RESET_PC  = 64'h0
) (
    input logic          clk,
    input logic          reset,
    imem_fetch_ctrl_if.master bus
);
    localparam int          CNT_W      = $clog2(MEM_BYTES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_BYTES - 1);
    // highest byte address from which a full 32-bit word can be read
    localparam logic [63:0] LAST_FETCH = 64'(MEM_BYTES - 4);
    localparam logic [31:0] NOP        = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  load_cnt_q, load_cnt_d;
    logic [63:0]       pc_q, pc_d;
    logic [63:0]       if_pc_q, if_pc_d;
    logic [31:0]       if_instr_q, if_instr_d;
    logic              if_valid_q, if_valid_d;
    logic              fault_q, fault_d;

    logic              load_ready;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [63:0]       mem_addr;
    logic              bad_pc;

    // A fetch address is unusable if misaligned or if the word would run
    // past the end of memory; wrapped PCs land in the range failure too.
    assign bad_pc = (pc_q[1:0] != 2'b00) || (pc_q > LAST_FETCH);

    // State register and all datapath registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_LOAD;
            load_cnt_q <= '0;
            pc_q       <= RESET_PC;
            if_pc_q    <= 64'h0;
            if_instr_q <= NOP;
            if_valid_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            if_valid_q <= if_valid_d;
            fault_q    <= fault_d;
        end
    end

    // Next-state logic and memory-port steering for each phase.
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        if_valid_d = if_valid_q;
        fault_d    = fault_q;
        load_ready = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = 8'h00;
        mem_addr   = pc_q;

        case (state_q)
            ST_LOAD: begin
                load_ready = 1'b1;
                mem_addr   = 64'(load_cnt_q);
                mem_wdata  = bus.load_byte;
                // a reset on this edge aborts the transfer, so no write either
                mem_we     = bus.load_valid && !reset;
                if (bus.load_valid) begin
                    load_cnt_d = load_cnt_q + CNT_W'(1);
                    if (bus.load_last || (load_cnt_q == LAST_CNT)) begin
                        state_d = ST_RUN;
                        pc_d    = RESET_PC;
                    end
                end
            end
            ST_RUN: begin
                if (bus.redirect_valid) begin
                    // flush: the target is checked only when fetched from
                    pc_d       = bus.redirect_pc;
                    if_valid_d = 1'b0;
                end else if (bus.stall) begin
                    // hold everything
                end else if (bad_pc) begin
                    state_d    = ST_FAULT;
                    fault_d    = 1'b1;
                    if_valid_d = 1'b0;
                end else begin
                    if_pc_d    = pc_q;
                    if_instr_d = bus.instruction;
                    if_valid_d = 1'b1;
                    pc_d       = pc_q + 64'd4;
                end
            end
            ST_FAULT: begin
                // parked until reset
            end
            default: begin
                state_d    = ST_FAULT;
                fault_d    = 1'b1;
                if_valid_d = 1'b0;
            end
        endcase
    end

    assign bus.load_ready = load_ready;
    assign bus.mem_we     = mem_we;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.mem_addr   = mem_addr;
    assign bus.if_pc      = if_pc_q;
    assign bus.if_instr   = if_instr_q;
    assign bus.if_valid   = if_valid_q;
    assign bus.running    = (state_q == ST_RUN);
    assign bus.fault      = fault_q;
endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Sequences the byte-wide instruction memory (MEM_BYTES x 8, little-endian 32-bit reads at byte address).
- After reset it runs a LOAD phase: a byte-serial program loader writes the image through a valid/ready port.
- It then switches to RUN: it owns the memory address, drives the program counter, and registers the fetched word into the IF/ID output under stall/redirect control from the pipeline.
- Sits between the loader/testbench, the instruction memory and the decode stage.

Parameters:
- MEM_BYTES, 128, instruction memory size in bytes; power of two, >= 8.
- RESET_PC, 64'h0, PC value loaded on entering RUN; must be 4-byte aligned.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- load_valid  in  1  loader presents a byte.
- load_byte  in  8  program byte; written to the current load address.
- load_last  in  1  qualifies the final byte of the image.
- load_ready  out  1  controller accepts a byte this cycle.
- mem_addr  out  64  byte address to the memory; used for both write and read.
- mem_we  out  1  byte write strobe to the memory.
- mem_wdata  out  8  byte written to the memory.
- instruction  in  32  combinational read data from the memory at mem_addr.
- stall  in  1  hazard unit holds fetch.
- redirect_valid  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  64  redirect target.
- if_pc  out  64  registered PC of if_instr.
- if_instr  out  32  registered fetched instruction.
- if_valid  out  1  if_instr is valid (0 means bubble).
- running  out  1  state == RUN.
- fault  out  1  sticky fetch fault.

Behaviour:
- States: LOAD, RUN, FAULT. The state register is 2 bits.
- Reset (synchronous, priority over everything):
  - state=LOAD, load_cnt=0, pc=RESET_PC.
  - if_pc=0, if_instr=32'h0000_0013 (NOP), if_valid=0, fault=0.
  - Memory contents are not touched.
  - Reset asserted mid-load or mid-run aborts the current operation in the same edge.
- LOAD state:
  - Combinational outputs: load_ready=1, mem_addr=load_cnt (zero-extended), mem_wdata=load_byte, mem_we=load_valid.
  - A byte transfers when load_valid && load_ready. On transfer, load_cnt increments by 1.
  - Transition to RUN on a transfer with load_last=1, or on a transfer at load_cnt==MEM_BYTES-1 (memory full; load_last not required).
  - Entering RUN sets pc=RESET_PC.
  - Outputs during LOAD: running=0, if_valid=0.
- RUN state:
  - Combinational outputs: load_ready=0, mem_we=0, mem_addr=pc.
  - load_valid is ignored; no writes occur.
  - bad_pc = (pc[1:0]!=0) || (pc > MEM_BYTES-4).
  - Per-edge priority, highest first:
    1. redirect_valid: pc<=redirect_pc, if_valid<=0, if_pc/if_instr hold. Wins over stall; applies even if the current pc is bad.
    2. stall: pc, if_pc, if_instr and if_valid all hold.
    3. bad_pc: state<=FAULT, fault<=1, if_valid<=0.
    4. Otherwise fetch: if_pc<=pc, if_instr<=instruction, if_valid<=1, pc<=pc+4.
  - Fetch latency: 1 cycle from pc to if_instr. Sustained throughput is one instruction per cycle.
  - A bad redirect target is not faulted when accepted; it faults on the first unstalled cycle that tries to fetch from it.
  - PC arithmetic is 64-bit with wrap; any wrapped value is caught by the bad_pc range check.
- FAULT state:
  - Combinational outputs: load_ready=0, mem_we=0, mem_addr=pc.
  - Outputs: fault=1, if_valid=0, running=0.
  - The state is held and all inputs are ignored until reset.
- running=1 only in RUN.

Test Plan:
1. Reset, then load 8 bytes 93,00,A0,00,13,01,40,01 with load_last on the 8th -> mem_we pulses at addresses 0..7. running=1 on the cycle after the 8th transfer, and pc=0.
2. Continue from 1 with no stall -> if_instr=00A00093 with if_pc=0, next cycle if_instr=01400113 with if_pc=4. if_valid stays 1.
3. Assert stall for 3 cycles mid-run -> if_pc, if_instr and pc frozen for exactly 3 cycles, then fetch resumes at the held pc with no instruction skipped or duplicated.
4. Assert redirect_valid with redirect_pc=0x40 together with stall -> next cycle if_valid=0. The following cycle if_pc=0x40 and if_instr=mem[0x43:0x40].
5. Redirect to 0x42, then separately to 0x7E with MEM_BYTES=128 -> each produces fault=1 one unstalled cycle after the target is reached, with if_valid=0 and running=0. fault stays set until reset.
6. Load 128 bytes without load_last -> RUN is entered after the transfer at address 127. A load_valid pulse in RUN gives load_ready=0 and mem_we=0. Reset asserted mid-load at load_cnt=5 returns to LOAD with the next write at address 0.
